// File: rtl/discus_loader.sv
// Host byte-stream to snoop-port sequencer: P/M burst writes, R burst reads.
// Optional feature: define DISCUS_LOADER_CKSUM_EN to return a mod-256 payload sum after write bursts.
module discus_loader #(
  parameter logic [7:0] OP_PROG = 8'h50,
  parameter logic [7:0] OP_MEM  = 8'h4D,
  parameter logic [7:0] OP_READ = 8'h52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] snoopa,
  output logic [7:0] snoopd,
  output logic       snoopm,
  output logic       snoopp,
  input  logic [7:0] snoopq,
  output logic       busy,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_COUNT, S_WDATA, S_RADDR, S_RWAIT, S_RSEND, S_CKSUM
  } state_t;

  typedef enum logic [1:0] {K_PROG, K_MEM, K_READ} kind_t;

  state_t     state_q, state_d;
  kind_t      kind_q, kind_d;
  logic [7:0] addr_q, addr_d;
  logic [8:0] cnt_q, cnt_d;
  logic       rx_ready_q, rx_ready_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] snoopa_q, snoopa_d;
  logic [7:0] snoopd_q, snoopd_d;
  logic       snoopm_q, snoopm_d;
  logic       snoopp_q, snoopp_d;
  logic       busy_q, busy_d;
  logic [7:0] err_q, err_d;
  logic       rx_fire, tx_fire;
`ifdef DISCUS_LOADER_CKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  assign rx_fire = rx_valid && rx_ready_q;
  assign tx_fire = tx_valid_q && tx_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d    = state_q;
    kind_d     = kind_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    snoopa_d   = snoopa_q;
    snoopd_d   = snoopd_q;
    snoopm_d   = 1'b0;
    snoopp_d   = 1'b0;
    err_d      = err_q;
`ifdef DISCUS_LOADER_CKSUM_EN
    sum_d      = sum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          if (rx_data == OP_PROG) begin
            kind_d  = K_PROG;
            state_d = S_ADDR;
          end else if (rx_data == OP_MEM) begin
            kind_d  = K_MEM;
            state_d = S_ADDR;
          end else if (rx_data == OP_READ) begin
            kind_d  = K_READ;
            state_d = S_ADDR;
          end else if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
        end
      end
      S_ADDR: begin
        if (rx_fire) begin
          addr_d  = rx_data;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (rx_fire) begin
          cnt_d = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
`ifdef DISCUS_LOADER_CKSUM_EN
          sum_d = 8'd0;
`endif
          if (kind_q == K_READ) begin
            // The address is presented while in RADDR so snoopq is valid in RWAIT.
            snoopa_d = addr_q;
            state_d  = S_RADDR;
          end else begin
            state_d = S_WDATA;
          end
        end
      end
      S_WDATA: begin
        if (rx_fire) begin
          snoopa_d = addr_q;
          snoopd_d = rx_data;
          snoopp_d = (kind_q == K_PROG);
          snoopm_d = (kind_q == K_MEM);
          addr_d   = addr_q + 8'd1;
          cnt_d    = cnt_q - 9'd1;
`ifdef DISCUS_LOADER_CKSUM_EN
          sum_d    = sum_q + rx_data;
`endif
          if (cnt_q == 9'd1) begin
`ifdef DISCUS_LOADER_CKSUM_EN
            tx_data_d  = sum_q + rx_data;
            tx_valid_d = 1'b1;
            state_d    = S_CKSUM;
`else
            state_d    = S_IDLE;
`endif
          end
        end
      end
      S_RADDR: state_d = S_RWAIT;
      S_RWAIT: begin
        tx_data_d  = snoopq;
        tx_valid_d = 1'b1;
        state_d    = S_RSEND;
      end
      S_RSEND: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          addr_d     = addr_q + 8'd1;
          cnt_d      = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            state_d = S_IDLE;
          end else begin
            snoopa_d = addr_q + 8'd1;
            state_d  = S_RADDR;
          end
        end
      end
      S_CKSUM: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rx_ready_d = state_d inside {S_IDLE, S_ADDR, S_COUNT, S_WDATA};
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      kind_q     <= K_PROG;
      addr_q     <= 8'd0;
      cnt_q      <= 9'd0;
      rx_ready_q <= 1'b0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      snoopa_q   <= 8'd0;
      snoopd_q   <= 8'd0;
      snoopm_q   <= 1'b0;
      snoopp_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 8'd0;
`ifdef DISCUS_LOADER_CKSUM_EN
      sum_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rx_ready_q <= rx_ready_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      snoopa_q   <= snoopa_d;
      snoopd_q   <= snoopd_d;
      snoopm_q   <= snoopm_d;
      snoopp_q   <= snoopp_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
`ifdef DISCUS_LOADER_CKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign rx_ready  = rx_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign snoopa    = snoopa_q;
  assign snoopd    = snoopd_q;
  assign snoopm    = snoopm_q;
  assign snoopp    = snoopp_q;
  assign busy      = busy_q;
  assign err_count = err_q;

endmodule
